// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared stream defaults and counter-width helper
package axis_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    function automatic int axis_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_skid_ram.sv
// rtl/axis_skid_ram.sv - entry store: synchronous write, asynchronous read
module axis_skid_ram #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    // No reset: stale entries are unreachable once the pointers are cleared.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_skid_fifo.sv
// rtl/axis_skid_fifo.sv - registered-flag FWFT stream buffer; AXIS_SKID_PKT_CNT_EN adds pkt_cnt
module axis_skid_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH           = DEFAULT_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [DATA_BYTE_WIDTH-1:0]      keep_in,
    input  logic                            last_in,
    output logic                            ready_out,
    output logic                            valid_out,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [DATA_BYTE_WIDTH-1:0]      keep_out,
    output logic                            last_out,
    input  logic                            ready_in,
    output logic [axis_cnt_w(DEPTH)-1:0]    count
`ifdef AXIS_SKID_PKT_CNT_EN
    ,
    output logic [axis_cnt_w(DEPTH)-1:0]    pkt_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = axis_cnt_w(DEPTH);
    localparam int EW = DATA_WIDTH + DATA_BYTE_WIDTH + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_next;
    logic          push, pop;
    logic [EW-1:0] head;

    assign push       = valid_in & ready_out;
    assign pop        = valid_out & ready_in;
    assign count_next = count + CW'(push) - CW'(pop);

    axis_skid_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({last_in, keep_in, data_in}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    assign {last_out, keep_out, data_out} = head;

    // Flags are derived from the post-update count so neither port sees a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_out <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count     <= count_next;
            ready_out <= (count_next != CW'(DEPTH));
            valid_out <= (count_next != '0);
        end
    end

`ifdef AXIS_SKID_PKT_CNT_EN
    logic push_last, pop_last;

    assign push_last = push & last_in;
    assign pop_last  = pop & last_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            pkt_cnt <= pkt_cnt + CW'(push_last) - CW'(pop_last);
        end
    end
`endif

endmodule
